zc_phase_gen: RTL and testbench
===============================

Name: zc_phase_gen

Overview:
- Consumes the Zadoff-Chu length Nzc and root index q chosen upstream. Streams one phase index per sample for the base sequence x_q(m) = exp(-j*pi*q*m*(m+1)/Nzc).
- Covers n = 0..Mzc-1, with cyclic extension m = n mod Nzc.
- Output phase is an integer in [0, 2*Nzc). A downstream cos/sin LUT stage, scaled by 1/Nzc, turns it into DMRS samples.
- Multiplier-free: incremental modular accumulation only.

Parameters:
- W_N, 10, width of Mzc/Nzc/q inputs.
- W_P, 11, width of phase output; must hold 2*Nzc-1 (max 2*599-1 = 1197).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- Mzc  in  W_N  sequence length, sampled with start
- Nzc  in  W_N  ZC prime length (odd prime), sampled with start
- q  in  W_N  root index, sampled with start; legal range 1..Nzc-1
- out_ready  in  1  downstream accept
- out_valid  out  1  phase/n valid
- phase  out  W_P  q*m*(m+1) mod 2*Nzc
- n_idx  out  W_N  output sample index n
- last  out  1  asserted with the n = Mzc-1 beat
- busy  out  1  high outside IDLE
- param_err  out  1  one-cycle pulse on an illegal parameter set

Behaviour:
- Reset (async, rst_n=0): state=IDLE. out_valid=0, phase=0, n_idx=0, last=0, busy=0, param_err=0. All internal registers are cleared, including mid-run; no further beats are produced.
- States: IDLE, SETUP, RUN.
- IDLE -> SETUP on start=1. Mzc, Nzc and q are latched; busy=1 from the next cycle.
- start is ignored while busy.
- SETUP (1 cycle) runs the legality check. The set is illegal if any of: q==0, q>=Nzc, Mzc==0, Mzc<Nzc, Nzc<3, Nzc even.
  - Illegal: param_err pulses for 1 cycle and the block returns to IDLE with no beats.
  - Legal: initialise acc=0, d=2q (d<2Nzc is guaranteed), m=0, n=0; go to RUN.
- Latency: start at cycle t gives first out_valid=1 at t+2.
- RUN: out_valid=1, phase=acc, n_idx=n.
  - On each out_valid&&out_ready, advance:
    - acc' = modadd(acc, d)
    - d' = modadd(d, 2q)
    - n' = n+1
    - m' = m+1
  - On m==Nzc-1, force m'=0, acc'=0, d'=2q. These values equal the natural periodic ones; the bench checks they agree.
- modadd(a,b): 12-bit sum of a+b; if sum >= 2*Nzc, subtract 2*Nzc. Inputs are always < 2*Nzc.
- Backpressure: while out_valid && !out_ready, phase, n_idx and last are held stable; no state advances.
- Last beat: last=1 when n==Mzc-1. When accepted, return to IDLE with out_valid=0 and busy=0 in the next cycle. A new start is accepted in the cycle after busy falls.
- Throughput: 1 beat/cycle with out_ready held high. Mzc beats per request.
- Mzc, Nzc and q input changes after start have no effect until the next request.

Optional Feature:
- Macro: ZC_CONJ_EN.
- Defined: adds input port conj (1 bit), sampled with start. When conj=1, output phase = (2*Nzc - acc) mod 2*Nzc, giving the conjugate sequence for the receive-side correlator. acc=0 maps to 0.
- Undefined: no conj port; phase = acc always.
- Timing and handshake are identical in both builds.

Test Plan:
- Basic run: Nzc=31, q=1, Mzc=36, out_ready=1.
  - n=0..8 phases: 0, 2, 6, 12, 20, 30, 42, 56, 10.
  - n=31..35 phases: 0, 2, 6, 12, 20.
  - last on n=35; 36 beats total; first valid 2 cycles after start.
- Backpressure: same config, out_ready toggled pseudo-randomly. The beat sequence is identical to the basic run; outputs are stable during every stall.
- Illegal params: q=0; q=31 with Nzc=31; Mzc=20 with Nzc=31. Each gives a param_err 1-cycle pulse 2 cycles after start, zero beats, and busy low afterward.
- Large q: Nzc=139, q=138, Mzc=144.
  - n=1 -> 276, n=2 -> (138*6) mod 278 = 272.
  - The full stream matches the reference model q*m*(m+1) mod 278.
- Reset mid-run: rst_n=0 at n=10. Outputs clear immediately. A new start after release produces a fresh sequence from n=0, phase 0.
- ZC_CONJ_EN build: Nzc=31, q=1, conj=1 gives n=0..3 phases 0, 60, 56, 50. conj=0 reproduces the basic run.

Source files
------------

// File: rtl/zc_phase_gen.sv
// Zadoff-Chu phase index generator: streams q*m*(m+1) mod 2*Nzc, m = n mod Nzc, multiplier-free.
// Define ZC_CONJ_EN to add the conj input that selects the conjugate phase (2*Nzc - acc) mod 2*Nzc.
module zc_phase_gen #(
  parameter int W_N = 10,
  parameter int W_P = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W_N-1:0] Mzc,
  input  logic [W_N-1:0] Nzc,
  input  logic [W_N-1:0] q,
`ifdef ZC_CONJ_EN
  input  logic           conj,
`endif
  input  logic           out_ready,
  output logic           out_valid,
  output logic [W_P-1:0] phase,
  output logic [W_N-1:0] n_idx,
  output logic           last,
  output logic           busy,
  output logic           param_err
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

  state_t         state_reg;
  logic [W_N-1:0] mzc_reg, nzc_reg, q_reg, m_reg, n_reg;
  logic [W_P-1:0] two_n_reg, two_q_reg, acc_reg, d_reg;
`ifdef ZC_CONJ_EN
  logic           conj_reg;
`endif

  logic           accept, wrap, illegal;
  logic [W_P-1:0] acc_next, d_next;
  logic [W_N-1:0] m_next, n_next;

  // Both operands are already reduced, so a single conditional subtract suffices.
  function automatic logic [W_P-1:0] modadd(input logic [W_P-1:0] a, input logic [W_P-1:0] b,
                                            input logic [W_P-1:0] m2);
    logic [W_P:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m2})
      s = s - {1'b0, m2};
    return s[W_P-1:0];
  endfunction

  function automatic logic [W_P-1:0] phase_map(input logic [W_P-1:0] a);
    logic [W_P-1:0] p;
    p = a;
`ifdef ZC_CONJ_EN
    if (conj_reg && (a != '0))
      p = two_n_reg - a;
`endif
    return p;
  endfunction

  always_comb begin
    accept   = out_valid && out_ready;
    wrap     = (m_reg == nzc_reg - W_N'(1));
    illegal  = (q_reg == '0) || (q_reg >= nzc_reg) || (mzc_reg == '0) ||
               (mzc_reg < nzc_reg) || (nzc_reg < W_N'(3)) || !nzc_reg[0];
    acc_next = modadd(acc_reg, d_reg, two_n_reg);
    d_next   = modadd(d_reg, two_q_reg, two_n_reg);
    m_next   = m_reg + W_N'(1);
    n_next   = n_reg + W_N'(1);
    // Restart the period explicitly at m = Nzc-1 rather than trusting the accumulator.
    if (wrap) begin
      acc_next = '0;
      d_next   = two_q_reg;
      m_next   = '0;
    end
  end

  assign n_idx = n_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mzc_reg   <= '0;
      nzc_reg   <= '0;
      q_reg     <= '0;
      two_n_reg <= '0;
      two_q_reg <= '0;
      acc_reg   <= '0;
      d_reg     <= '0;
      m_reg     <= '0;
      n_reg     <= '0;
`ifdef ZC_CONJ_EN
      conj_reg  <= 1'b0;
`endif
      out_valid <= 1'b0;
      phase     <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      param_err <= 1'b0;
    end else begin
      param_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mzc_reg   <= Mzc;
            nzc_reg   <= Nzc;
            q_reg     <= q;
            two_n_reg <= W_P'({Nzc, 1'b0});
            two_q_reg <= W_P'({q, 1'b0});
`ifdef ZC_CONJ_EN
            conj_reg  <= conj;
`endif
            busy      <= 1'b1;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          if (illegal) begin
            param_err <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            acc_reg   <= '0;
            d_reg     <= two_q_reg;
            m_reg     <= '0;
            n_reg     <= '0;
            phase     <= '0;
            last      <= (mzc_reg == W_N'(1));
            out_valid <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last) begin
              out_valid <= 1'b0;
              last      <= 1'b0;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              acc_reg <= acc_next;
              d_reg   <= d_next;
              m_reg   <= m_next;
              n_reg   <= n_next;
              phase   <= phase_map(acc_next);
              last    <= (n_next == mzc_reg - W_N'(1));
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zc_phase_gen.sv
// Scoreboard bench for zc_phase_gen: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_zc_phase_gen;
  localparam int W_N = 10;
  localparam int W_P = 11;

  logic           clk = 1'b0;
  logic           rst_n, start, out_ready;
  logic [W_N-1:0] Mzc, Nzc, q;
`ifdef ZC_CONJ_EN
  logic           conj;
`endif
  logic           out_valid, last, busy, param_err;
  logic [W_P-1:0] phase;
  logic [W_N-1:0] n_idx;

  zc_phase_gen #(.W_N(W_N), .W_P(W_P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Mzc(Mzc), .Nzc(Nzc), .q(q),
`ifdef ZC_CONJ_EN
    .conj(conj),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .phase(phase), .n_idx(n_idx),
    .last(last), .busy(busy), .param_err(param_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int n;
    bit last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beat_cnt = 0;
  bit    sb_en = 1'b1;
  bit    rnd_ready = 1'b0;
  int    hand31[9] = '{0, 2, 6, 12, 20, 30, 42, 56, 10};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hand-computed values where the test plan lists them, arithmetic reference elsewhere.
  function automatic int model_phase(input int n, input int nz, input int qq, input bit cj);
    int m, p;
    m = n % nz;
    if (nz == 31 && qq == 1 && m < 9)          p = hand31[m];
    else if (nz == 139 && qq == 138 && m == 1) p = 276;
    else if (nz == 139 && qq == 138 && m == 2) p = 272;
    else                                       p = (qq * m * (m + 1)) % (2 * nz);
    if (cj && p != 0) p = 2 * nz - p;
    return p;
  endfunction

  // Downstream acceptance pattern, changed just after each active edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: checks every accepted beat against the scoreboard and every stall for stability.
  bit   held = 1'b0;
  int   h_phase, h_n;
  logic h_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!(out_valid && int'(phase) == h_phase && int'(n_idx) == h_n && last == h_last)) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0d phase=%0d n=%0d last=%0d expected valid=1 phase=%0d n=%0d last=%0d",
                   out_valid, phase, n_idx, last, h_phase, h_n, h_last);
        end
      end
      if (out_valid && out_ready && sb_en) begin
        beat_t e;
        beat_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got phase=%0d n=%0d expected no beat", phase, n_idx);
        end else begin
          e = sb.pop_front();
          if (int'(phase) != e.phase || int'(n_idx) != e.n || last != e.last) begin
            errors++;
            $display("FAIL beat n=%0d: got phase=%0d n=%0d last=%0d expected phase=%0d n=%0d last=%0d",
                     e.n, phase, n_idx, last, e.phase, e.n, e.last);
          end
        end
      end
      held    = out_valid && !out_ready;
      h_phase = int'(phase);
      h_n     = int'(n_idx);
      h_last  = last;
    end
  end

  task automatic issue_start(input int mz, input int nz, input int qq, input bit cj);
    @(posedge clk);
    #1;
    Mzc   = W_N'(mz);
    Nzc   = W_N'(nz);
    q     = W_N'(qq);
`ifdef ZC_CONJ_EN
    conj  = cj;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the parameter inputs: the latched request must not see them.
    Mzc   = W_N'(5);
    Nzc   = W_N'(7);
    q     = W_N'(3);
`ifdef ZC_CONJ_EN
    conj  = ~cj;
`endif
  endtask

  task automatic run_seq(input string tag, input int mz, input int nz, input int qq,
                         input bit cj, input bit exp_err, input bit rr);
    int    k;
    beat_t b;
    rnd_ready = rr;
    beat_cnt  = 0;
    if (!exp_err) begin
      for (int n = 0; n < mz; n++) begin
        b.phase = model_phase(n, nz, qq, cj);
        b.n     = n;
        b.last  = (n == mz - 1);
        sb.push_back(b);
      end
    end
    issue_start(mz, nz, qq, cj);
    @(negedge clk);
    check({tag, "_setup_busy"}, int'(busy), 1);
    check({tag, "_setup_valid"}, int'(out_valid), 0);
    @(negedge clk);
    check({tag, "_first_valid"}, int'(out_valid), exp_err ? 0 : 1);
    check({tag, "_param_err"}, int'(param_err), exp_err ? 1 : 0);
    if (exp_err) begin
      @(negedge clk);
      check({tag, "_param_err_pulse"}, int'(param_err), 0);
      check({tag, "_busy_after_err"}, int'(busy), 0);
      check({tag, "_no_beats"}, beat_cnt, 0);
    end else begin
      k = 0;
      while ((sb.size() != 0 || out_valid) && k < 5000) begin
        @(negedge clk);
        k++;
      end
      if (k >= 5000) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got %0d beats pending expected 0", tag, sb.size());
        sb.delete();
      end
      check({tag, "_beat_count"}, beat_cnt, mz);
      check({tag, "_busy_done"}, int'(busy), 0);
    end
    $display("run %s: Mzc=%0d Nzc=%0d q=%0d conj=%0d beats=%0d", tag, mz, nz, qq, cj, beat_cnt);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_n_idx"}, int'(n_idx), 0);
    check({tag, "_last"}, int'(last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_param_err"}, int'(param_err), 0);
  endtask

  task automatic reset_mid_run();
    int k;
    rnd_ready = 1'b0;
    sb_en     = 1'b0;
    issue_start(36, 31, 1, 1'b0);
    k = 0;
    while (!(out_valid && n_idx == W_N'(10)) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reach_n10", k < 200 ? 1 : 0, 1);
    check("rst_mid_phase_n10", int'(phase), 48);
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    sb_en = 1'b1;
    @(negedge clk);
    check_reset_state("rst_mid_release");
    $display("run reset_mid_run: cleared at n=10");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    Mzc   = '0;
    Nzc   = '0;
    q     = '0;
`ifdef ZC_CONJ_EN
    conj  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_seq("basic", 36, 31, 1, 1'b0, 1'b0, 1'b0);
    run_seq("backpressure", 36, 31, 1, 1'b0, 1'b0, 1'b1);
    run_seq("illegal_q0", 36, 31, 0, 1'b0, 1'b1, 1'b0);
    run_seq("illegal_q_eq_n", 36, 31, 31, 1'b0, 1'b1, 1'b0);
    run_seq("illegal_short_m", 20, 31, 1, 1'b0, 1'b1, 1'b0);
    run_seq("illegal_even_n", 36, 32, 1, 1'b0, 1'b1, 1'b0);
    run_seq("large_q", 144, 139, 138, 1'b0, 1'b0, 1'b0);
    run_seq("large_q_bp", 144, 139, 138, 1'b0, 1'b0, 1'b1);
    reset_mid_run();
    run_seq("after_reset", 36, 31, 1, 1'b0, 1'b0, 1'b0);
`ifdef ZC_CONJ_EN
    run_seq("conj1", 36, 31, 1, 1'b1, 1'b0, 1'b0);
    run_seq("conj1_bp", 36, 31, 1, 1'b1, 1'b0, 1'b1);
    run_seq("conj0", 36, 31, 1, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
